mem_port_arbiter: RTL

Arbiter and sequencer for the CPU's single-port unified memory. It shares one memory port between three requesters: the pipeline data stage (LDD/STD/LDI/STI, PUSH/POP), the external debug/program loader, and instruction fetch. It sits between the pipeline and the memory instance inside the CPU wrapper. It grants at most one access per cycle, returns read data with fixed latency, and guarantees fetch forward progress through a starvation counter.

---
 rtl/mem_port_arbiter_if.sv | 65 ++++++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every handshake and memory-side signal of mem_port_arbiter.
//   Requesters (data stage, loader, fetch):
//     *_req / *_we / *_addr / *_wdata  request and payload (fetch is read-only)
//     *_gnt                            access accepted this cycle
//     *_rvalid / *_rdata               read result, one cycle after the grant
//   Memory port:
//     mem_en / mem_we / mem_addr / mem_wdata  command from the arbiter
//     mem_rdata                               read data, one cycle after a read
//   Modports: master = requesters plus memory (the environment),
//             slave  = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified memory between the data stage, the debug/
//   program loader and instruction fetch. At most one access is granted per
//   cycle (combinational grant), read data returns one cycle later on the
//   owning port, and a starvation counter forces a fetch grant after
//   STARVE_MAX consecutive denied fetch-request cycles.
//   Ports:
//     clk   system clock, rising edge
//     rstn  asynchronous active-low reset
//     bus   mem_port_arbiter_if.slave: requester handshakes and memory port
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_L    = 2'd2,
        OWN_F    = 2'd3
    } owner_t;

    localparam logic [3:0] SC_MAX = 4'(STARVE_MAX);

    logic [3:0]    sc;
    owner_t        owner;
    owner_t        owner_nxt;
    logic          force_f;
    logic          gd, gl, gf;
    logic [DW-1:0] d_hold, l_hold, f_hold;
    logic          d_rv, l_rv, f_rv;

    assign force_f = bus.f_req && (sc == SC_MAX);

    always_comb begin
        gd = 1'b0;
        gl = 1'b0;
        gf = 1'b0;
        if (force_f)        gf = 1'b1;
        else if (bus.d_req) gd = 1'b1;
        else if (bus.l_req) gl = 1'b1;
        else if (bus.f_req) gf = 1'b1;
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (gd && !bus.d_we)      owner_nxt = OWN_D;
        else if (gl && !bus.l_we) owner_nxt = OWN_L;
        else if (gf)              owner_nxt = OWN_F;
    end

    assign bus.d_gnt     = gd;
    assign bus.l_gnt     = gl;
    assign bus.f_gnt     = gf;
    assign bus.mem_en    = gd | gl | gf;
    assign bus.mem_we    = (gd & bus.d_we) | (gl & bus.l_we);
    assign bus.mem_addr  = gd ? bus.d_addr  : gl ? bus.l_addr  : gf ? bus.f_addr : '0;
    assign bus.mem_wdata = gd ? bus.d_wdata : gl ? bus.l_wdata : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sc     <= '0;
            owner  <= OWN_NONE;
            d_hold <= '0;
            l_hold <= '0;
            f_hold <= '0;
        end else begin
            if (!bus.f_req || gf)  sc <= '0;
            else if (sc != SC_MAX) sc <= sc + 4'd1;
            owner <= owner_nxt;
            if (d_rv) d_hold <= bus.mem_rdata;
            if (l_rv) l_hold <= bus.mem_rdata;
            if (f_rv) f_hold <= bus.mem_rdata;
        end
    end

    // rvalid is a decode of the registered owner; during the return cycle
    // rdata passes the memory output straight through so the latency stays at
    // one cycle, and the hold register keeps it afterwards.
    assign d_rv = (owner == OWN_D);
    assign l_rv = (owner == OWN_L);
    assign f_rv = (owner == OWN_F);

    assign bus.d_rvalid = d_rv;
    assign bus.l_rvalid = l_rv;
    assign bus.f_rvalid = f_rv;
    assign bus.d_rdata  = d_rv ? bus.mem_rdata : d_hold;
    assign bus.l_rdata  = l_rv ? bus.mem_rdata : l_hold;
    assign bus.f_rdata  = f_rv ? bus.mem_rdata : f_hold;
endmodule
